// File: rtl/gat_load_sched.sv
// Load/compute/readback scheduler for the GAT accelerator: streams host words into
// four BRAM regions, waits for the accelerator, then streams feature words back out.
module gat_load_sched #(
    parameter int TOP_WIDTH = 32,
    parameter int ADDR_W    = 20,
    parameter int LEN_W     = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     h_data_len,
    input  logic [LEN_W-1:0]     h_node_info_len,
    input  logic [LEN_W-1:0]     wgt_len,
    input  logic [LEN_W-1:0]     subgraph_len,
    input  logic [LEN_W-1:0]     feat_len,
    input  logic                 s_valid,
    input  logic [TOP_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic [TOP_WIDTH-1:0] bram_din,
    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,
    output logic                 subgraph_bram_ena,
    output logic                 subgraph_bram_wea,
    output logic [ADDR_W+1:0]    bram_addra,
    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,
    input  logic                 gat_ready,
    output logic [ADDR_W+1:0]    feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0] feat_bram_dout,
    output logic                 m_valid,
    output logic [TOP_WIDTH-1:0] m_data,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [3:0] {
        IDLE, LD_HDATA, LD_NINFO, LD_WGT, LD_SUBG,
        WAIT_GAT, RD_ISSUE, RD_WAIT, RD_HOLD, FIN
    } state_t;

    state_t           state, next_state;
    logic [LEN_W-1:0] cnt, cnt_next, cnt_inc, cur_len;
    logic [LEN_W-1:0] hdata_len_q, ninfo_len_q, wgt_len_q, subg_len_q, feat_len_q;
    logic [3:0]       region, ena_q;
    logic [2:0]       pend_q, load_done_q;
    logic             load_state, hs, region_end, start_run;

    assign cnt_inc   = cnt + LEN_W'(1);
    assign start_run = (state == IDLE) && start;

    // One-hot region select and handshake decode for the four load states
    always_comb begin
        cur_len    = '0;
        region     = '0;
        load_state = 1'b0;
        case (state)
            LD_HDATA: begin cur_len = hdata_len_q; region = 4'b0001; load_state = 1'b1; end
            LD_NINFO: begin cur_len = ninfo_len_q; region = 4'b0010; load_state = 1'b1; end
            LD_WGT:   begin cur_len = wgt_len_q;   region = 4'b0100; load_state = 1'b1; end
            LD_SUBG:  begin cur_len = subg_len_q;  region = 4'b1000; load_state = 1'b1; end
            default:  ;
        endcase
        s_ready    = load_state && (cnt < cur_len);
        hs         = s_ready && s_valid;
        region_end = load_state && ((cur_len == '0) || (hs && (cnt_inc == cur_len)));
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (start) begin
                next_state = LD_HDATA;
                cnt_next   = '0;
            end
            LD_HDATA, LD_NINFO, LD_WGT, LD_SUBG: begin
                if (hs) cnt_next = cnt_inc;
                if (region_end) begin
                    cnt_next = '0;
                    case (state)
                        LD_HDATA: next_state = LD_NINFO;
                        LD_NINFO: next_state = LD_WGT;
                        LD_WGT:   next_state = LD_SUBG;
                        default:  next_state = WAIT_GAT;
                    endcase
                end
            end
            WAIT_GAT: begin
                if (feat_len_q == '0)  next_state = FIN;
                else if (gat_ready)    next_state = RD_ISSUE;
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = RD_HOLD;
            RD_HOLD: if (m_ready) begin
                if (cnt < feat_len_q) cnt_next = cnt_inc;
                next_state = (cnt_inc >= feat_len_q) ? FIN : RD_ISSUE;
            end
            FIN:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Run control: lengths are captured only when a run starts, so a start while busy is inert
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdata_len_q <= '0;
            ninfo_len_q <= '0;
            wgt_len_q   <= '0;
            subg_len_q  <= '0;
            feat_len_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pend_q      <= '0;
            load_done_q <= '0;
        end else begin
            done <= (next_state == FIN);
            if (start_run) begin
                hdata_len_q <= h_data_len;
                ninfo_len_q <= h_node_info_len;
                wgt_len_q   <= wgt_len;
                subg_len_q  <= subgraph_len;
                feat_len_q  <= feat_len;
                busy        <= 1'b1;
                pend_q      <= '0;
                load_done_q <= '0;
            end else begin
                if (state == FIN) busy <= 1'b0;
                pend_q      <= region_end ? region[2:0] : 3'b000;
                load_done_q <= load_done_q | pend_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q      <= '0;
            bram_din   <= '0;
            bram_addra <= '0;
        end else begin
            ena_q <= hs ? region : 4'b0000;
            if (hs) begin
                bram_din   <= s_data;
                bram_addra <= {ADDR_W'(cnt), 2'b00};
            end
        end
    end

    // Readback: address issued on entry to RD_ISSUE, BRAM data captured entering RD_HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_bram_addrb <= '0;
            m_valid         <= 1'b0;
            m_data          <= '0;
        end else begin
            if (next_state == RD_ISSUE && state != RD_ISSUE)
                feat_bram_addrb <= {ADDR_W'(cnt_next), 2'b00};
            if (state == RD_WAIT) begin
                m_data  <= feat_bram_dout;
                m_valid <= 1'b1;
            end else if (state == RD_HOLD && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign h_data_bram_ena            = ena_q[0];
    assign h_data_bram_wea            = ena_q[0];
    assign h_node_info_bram_ena       = ena_q[1];
    assign h_node_info_bram_wea       = ena_q[1];
    assign wgt_bram_ena               = ena_q[2];
    assign wgt_bram_wea               = ena_q[2];
    assign subgraph_bram_ena          = ena_q[3];
    assign subgraph_bram_wea          = ena_q[3];
    assign h_data_bram_load_done      = load_done_q[0];
    assign h_node_info_bram_load_done = load_done_q[1];
    assign wgt_bram_load_done         = load_done_q[2];

endmodule

// File: tb/tb_gat_load_sched.sv
// Directed bench for gat_load_sched: cycle-exact load tables, readback with back-pressure,
// zero-length skipping, mid-run reset and start-while-busy.
module tb_gat_load_sched;

    localparam int TW = 32;
    localparam int AW = 20;
    localparam int LW = 20;
    localparam logic [TW-1:0] BASE = 32'hD000_0000;

    logic          clk = 1'b0;
    logic          rst_n, start, s_valid, s_ready, gat_ready, m_valid, m_ready, busy, done;
    logic [LW-1:0] h_data_len, h_node_info_len, wgt_len, subgraph_len, feat_len;
    logic [TW-1:0] s_data, bram_din, feat_bram_dout, m_data;
    logic [AW+1:0] bram_addra, feat_bram_addrb;
    logic h_data_bram_ena, h_data_bram_wea, h_node_info_bram_ena, h_node_info_bram_wea;
    logic wgt_bram_ena, wgt_bram_wea, subgraph_bram_ena, subgraph_bram_wea;
    logic h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;

    logic [3:0] ena, wea;
    logic [2:0] ld;
    assign ena = {subgraph_bram_ena, wgt_bram_ena, h_node_info_bram_ena, h_data_bram_ena};
    assign wea = {subgraph_bram_wea, wgt_bram_wea, h_node_info_bram_wea, h_data_bram_wea};
    assign ld  = {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done};

    int total = 0;
    int bad   = 0;

    gat_load_sched #(.TOP_WIDTH(TW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .h_data_len(h_data_len), .h_node_info_len(h_node_info_len), .wgt_len(wgt_len),
        .subgraph_len(subgraph_len), .feat_len(feat_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .bram_din(bram_din),
        .h_data_bram_ena(h_data_bram_ena), .h_data_bram_wea(h_data_bram_wea),
        .h_node_info_bram_ena(h_node_info_bram_ena), .h_node_info_bram_wea(h_node_info_bram_wea),
        .wgt_bram_ena(wgt_bram_ena), .wgt_bram_wea(wgt_bram_wea),
        .subgraph_bram_ena(subgraph_bram_ena), .subgraph_bram_wea(subgraph_bram_wea),
        .bram_addra(bram_addra),
        .h_data_bram_load_done(h_data_bram_load_done),
        .h_node_info_bram_load_done(h_node_info_bram_load_done),
        .wgt_bram_load_done(wgt_bram_load_done),
        .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Feature BRAM with one-cycle read latency; word content encodes its byte address
    always @(posedge clk) feat_bram_dout <= 32'hFE00_0000 | TW'(feat_bram_addrb);

    // Advance one clock; the host stream moves to its next word after each accepted handshake
    task automatic step();
        logic hs;
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) s_data = s_data + 32'd1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_output({pfx, "_s_ready"}, 64'(s_ready), 64'd0);
        check_output({pfx, "_ena"}, 64'(ena), 64'd0);
        check_output({pfx, "_wea"}, 64'(wea), 64'd0);
        check_output({pfx, "_din"}, 64'(bram_din), 64'd0);
        check_output({pfx, "_addra"}, 64'(bram_addra), 64'd0);
        check_output({pfx, "_load_done"}, 64'(ld), 64'd0);
        check_output({pfx, "_addrb"}, 64'(feat_bram_addrb), 64'd0);
        check_output({pfx, "_m_valid"}, 64'(m_valid), 64'd0);
        check_output({pfx, "_m_data"}, 64'(m_data), 64'd0);
        check_output({pfx, "_busy"}, 64'(busy), 64'd0);
        check_output({pfx, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_lengths(input int a, input int b, input int c, input int d, input int e);
        h_data_len      = LW'(a);
        h_node_info_len = LW'(b);
        wgt_len         = LW'(c);
        subgraph_len    = LW'(d);
        feat_len        = LW'(e);
    endtask

    // Hand-computed per-cycle expectations, index 0 = first cycle after the start edge
    int t1_ena  [11] = '{0, 1, 1, 1, 2, 2, 4, 4, 4, 4, 8};
    int t1_addr [11] = '{0, 0, 4, 8, 0, 4, 0, 4, 8, 12, 0};
    int t1_word [11] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int t1_ld   [11] = '{0, 0, 0, 0, 1, 1, 3, 3, 3, 3, 7};
    int t1_rdy  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    int t2_sv   [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    int t2_ena  [12] = '{0, 1, 0, 0, 4, 0, 4, 0, 4, 0, 0, 0};
    int t2_addr [12] = '{0, 0, 0, 0, 0, 0, 4, 0, 8, 0, 0, 0};
    int t2_word [12] = '{0, 0, 0, 0, 1, 0, 2, 0, 3, 0, 0, 0};
    int t2_ld   [12] = '{0, 0, 1, 3, 3, 3, 3, 3, 3, 7, 7, 7};
    int t2_rdy  [12] = '{1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int t2_done [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int t2_busy [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        logic seen;
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        gat_ready = 1'b0; m_ready = 1'b0;
        set_lengths(0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        $display("[TB] full run: lengths 3,2,4,1,2");
        set_lengths(3, 2, 4, 1, 2);
        s_data  = BASE;
        s_valid = 1'b1;
        pulse_start();
        for (int c = 0; c < 11; c++) begin
            check_output($sformatf("t1_ena_c%0d", c), 64'(ena), 64'(t1_ena[c]));
            check_output($sformatf("t1_wea_c%0d", c), 64'(wea), 64'(t1_ena[c]));
            check_output($sformatf("t1_s_ready_c%0d", c), 64'(s_ready), 64'(t1_rdy[c]));
            check_output($sformatf("t1_load_done_c%0d", c), 64'(ld), 64'(t1_ld[c]));
            check_output($sformatf("t1_busy_c%0d", c), 64'(busy), 64'd1);
            if (t1_ena[c] != 0) begin
                check_output($sformatf("t1_addra_c%0d", c), 64'(bram_addra), 64'(t1_addr[c]));
                check_output($sformatf("t1_din_c%0d", c), 64'(bram_din), 64'(BASE + TW'(t1_word[c])));
            end
            if (c < 10) step();
        end

        s_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                set_lengths(7, 7, 7, 7, 7);
                start = 1'b1;
            end
            step();
            start = 1'b0;
            check_output($sformatf("t1_wait_m_valid_%0d", i), 64'(m_valid), 64'd0);
            check_output($sformatf("t1_wait_ena_%0d", i), 64'(ena), 64'd0);
            check_output($sformatf("t1_wait_load_done_%0d", i), 64'(ld), 64'd7);
            check_output($sformatf("t1_wait_busy_%0d", i), 64'(busy), 64'd1);
        end

        gat_ready = 1'b1;
        step();
        gat_ready = 1'b0;
        check_output("t1_addrb_word0", 64'(feat_bram_addrb), 64'd0);
        check_output("t1_issue0_m_valid", 64'(m_valid), 64'd0);
        step();
        step();
        check_output("t1_hold0_m_valid", 64'(m_valid), 64'd1);
        check_output("t1_hold0_m_data", 64'(m_data), 64'h0000_0000_FE00_0000);
        for (int i = 0; i < 10; i++) begin
            step();
            check_output($sformatf("t1_stall_m_valid_%0d", i), 64'(m_valid), 64'd1);
            check_output($sformatf("t1_stall_m_data_%0d", i), 64'(m_data), 64'h0000_0000_FE00_0000);
            check_output($sformatf("t1_stall_done_%0d", i), 64'(done), 64'd0);
        end
        m_ready = 1'b1;
        step();
        check_output("t1_issue1_m_valid", 64'(m_valid), 64'd0);
        check_output("t1_addrb_word1", 64'(feat_bram_addrb), 64'd4);
        step();
        step();
        check_output("t1_hold1_m_valid", 64'(m_valid), 64'd1);
        check_output("t1_hold1_m_data", 64'(m_data), 64'h0000_0000_FE00_0004);
        check_output("t1_hold1_done", 64'(done), 64'd0);
        step();
        m_ready = 1'b0;
        check_output("t1_fin_done", 64'(done), 64'd1);
        check_output("t1_fin_m_valid", 64'(m_valid), 64'd0);
        step();
        check_output("t1_after_done", 64'(done), 64'd0);
        check_output("t1_after_busy", 64'(busy), 64'd0);
        check_output("t1_after_load_done", 64'(ld), 64'd7);

        $display("[TB] zero-length regions and toggling s_valid");
        set_lengths(1, 0, 3, 0, 0);
        s_data  = BASE;
        s_valid = 1'b0;
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            s_valid = t2_sv[c][0];
            check_output($sformatf("t2_ena_c%0d", c), 64'(ena), 64'(t2_ena[c]));
            check_output($sformatf("t2_s_ready_c%0d", c), 64'(s_ready), 64'(t2_rdy[c]));
            check_output($sformatf("t2_load_done_c%0d", c), 64'(ld), 64'(t2_ld[c]));
            check_output($sformatf("t2_done_c%0d", c), 64'(done), 64'(t2_done[c]));
            check_output($sformatf("t2_busy_c%0d", c), 64'(busy), 64'(t2_busy[c]));
            if (t2_ena[c] != 0) begin
                check_output($sformatf("t2_addra_c%0d", c), 64'(bram_addra), 64'(t2_addr[c]));
                check_output($sformatf("t2_din_c%0d", c), 64'(bram_din), 64'(BASE + TW'(t2_word[c])));
            end
        end

        $display("[TB] reset during weight load");
        set_lengths(1, 1, 4, 1, 1);
        s_data  = BASE;
        s_valid = 1'b1;
        pulse_start();
        repeat (4) step();
        check_output("t3_pre_ena", 64'(ena), 64'd4);
        check_output("t3_pre_addra", 64'(bram_addra), 64'd4);
        check_output("t3_pre_load_done", 64'(ld), 64'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("t3_async");
        for (int i = 0; i < 2; i++) begin
            step();
            check_output($sformatf("t3_held_ena_%0d", i), 64'(ena), 64'd0);
            check_output($sformatf("t3_held_s_ready_%0d", i), 64'(s_ready), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output($sformatf("t3_idle_ena_%0d", i), 64'(ena), 64'd0);
            check_output($sformatf("t3_idle_busy_%0d", i), 64'(busy), 64'd0);
            check_output($sformatf("t3_idle_m_valid_%0d", i), 64'(m_valid), 64'd0);
        end
        set_lengths(2, 1, 1, 1, 0);
        s_data = BASE;
        pulse_start();
        check_output("t3_restart_s_ready", 64'(s_ready), 64'd1);
        check_output("t3_restart_busy", 64'(busy), 64'd1);
        step();
        check_output("t3_restart_ena0", 64'(ena), 64'd1);
        check_output("t3_restart_addra0", 64'(bram_addra), 64'd0);
        check_output("t3_restart_din0", 64'(bram_din), 64'(BASE));
        step();
        check_output("t3_restart_ena1", 64'(ena), 64'd1);
        check_output("t3_restart_addra1", 64'(bram_addra), 64'd4);
        check_output("t3_restart_din1", 64'(bram_din), 64'(BASE + 32'd1));
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check_output("t3_done_seen", 64'(seen), 64'd1);
        step();
        check_output("t3_final_busy", 64'(busy), 64'd0);
        check_output("t3_final_load_done", 64'(ld), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
